// File: rtl/uart_tx_top_if.sv
// Handshake and serial-line signals between the data source and uart_tx_top.
// The source uses the master modport; the transmitter uses the slave modport.
interface uart_tx_top_if;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       BUSY;

  modport master (
    output P_DATA,
    output DATA_VALID,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  BUSY
  );

  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output BUSY
  );
endinterface

// File: rtl/uart_tx_top.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, one stop bit; one bit per clock.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_top #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic          CLK,
  input logic          RST,
  uart_tx_top_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  localparam logic [2:0] LastBit = 3'(DATA_WIDTH - 1);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [2:0]              cnt_q;
  logic                    tx_q;
  logic                    busy_q;
`ifdef UART_TX_PARITY_EN
  logic                    par_en_q;
  logic                    par_typ_q;
`else
  logic                    unused_par;
  assign unused_par = bus.PAR_EN ^ bus.PAR_TYP;
`endif

  // Outputs are registered alongside the state so they reflect the state entered at each edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      data_q    <= '0;
      cnt_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.DATA_VALID) begin
            data_q    <= bus.P_DATA;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
`endif
            state_q   <= StStart;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StStart: begin
          state_q <= StData;
          cnt_q   <= '0;
          tx_q    <= data_q[0];
        end
        StData: begin
          if (cnt_q == LastBit) begin
            cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_q <= StParity;
              tx_q    <= (^data_q) ^ par_typ_q;
            end else begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end
`else
            state_q <= StStop;
            tx_q    <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 3'd1;
            tx_q  <= data_q[cnt_q + 3'd1];
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          state_q <= StStop;
          tx_q    <= 1'b1;
        end
`endif
        StStop: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top; expected frames are hand-computed for the active build
// (UART_TX_PARITY_EN defined: 11-bit parity frames, otherwise 10-bit frames).
module tb_uart_tx_top;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  uart_tx_top_if bus ();

  uart_tx_top #(.DATA_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef UART_TX_PARITY_EN
  localparam int         NPar   = 11;
  localparam logic [10:0] ExpA9 = 11'b01001010101;  // even parity 0
  localparam logic [10:0] ExpAB = 11'b01101010101;  // odd parity 0
  localparam logic [10:0] Exp55 = 11'b01010101001;  // even parity 0, unaffected by mid-frame changes
`else
  localparam int         NPar   = 10;
  localparam logic [10:0] ExpA9 = 11'b00100101011;
  localparam logic [10:0] ExpAB = 11'b00110101011;
  localparam logic [10:0] Exp55 = 11'b00101010101;
`endif
  localparam logic [10:0] ExpE9 = 11'b00100101111;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, bus.TX_OUT, 1'b1);
    check({tag, "_busy"}, bus.BUSY, 1'b0);
  endtask

  // Called at the negedge where DATA_VALID was raised; checks every bit and the idle after it.
  task automatic run_frame(input string tag, input logic [10:0] exp, input int n,
                           input bit hold, input bit mangle);
    @(negedge clk);
    if (!hold) bus.DATA_VALID = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("%s_bit%0d", tag, j), bus.TX_OUT, exp[n-1-j]);
      check($sformatf("%s_busy%0d", tag, j), bus.BUSY, 1'b1);
      if (mangle && j == 3) begin
        bus.P_DATA     = 8'hFF;
        bus.PAR_TYP    = ~bus.PAR_TYP;
        bus.DATA_VALID = 1'b1;
      end
      if (mangle && j == 4) bus.DATA_VALID = 1'b0;
    end
    @(negedge clk);
    check_idle({tag, "_end"});
  endtask

  task automatic load(input logic [7:0] d, input logic pe, input logic pt);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.DATA_VALID = 1'b1;
  endtask

  initial begin
    // Reset held for two edges with a pending request.
    rst = 1'b1;
    load(8'hA9, 1'b1, 1'b0);
    @(negedge clk);
    check_idle("rst1");
    @(negedge clk);
    check_idle("rst2");
    rst = 1'b0;

    // Even parity, 0xA9; request still high from reset is accepted on the first free edge.
    run_frame("even_a9", ExpA9, NPar, 1'b0, 1'b0);

    // Odd parity, 0xAB.
    load(8'hAB, 1'b1, 1'b1);
    run_frame("odd_ab", ExpAB, NPar, 1'b0, 1'b0);

    // No parity, 0xE9.
    load(8'hE9, 1'b0, 1'b0);
    run_frame("nopar_e9", ExpE9, 10, 1'b0, 1'b0);

    // Mid-frame input changes must not disturb 0x55 or start a second frame.
    load(8'h55, 1'b1, 1'b0);
    run_frame("mid_55", Exp55, NPar, 1'b0, 1'b1);
    @(negedge clk);
    check_idle("mid_noframe1");
    @(negedge clk);
    check_idle("mid_noframe2");

    // Mid-frame reset during data bit 3 of 0x00.
    load(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    bus.DATA_VALID = 1'b0;
    check("abort_start", bus.TX_OUT, 1'b0);
    repeat (4) @(negedge clk);
    check("abort_bit3", bus.TX_OUT, 1'b0);
    check("abort_busy3", bus.BUSY, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("abort_rst");
    rst = 1'b0;
    @(negedge clk);
    check_idle("abort_after");

    // Back-to-back: DATA_VALID held high across two frames, exactly one idle cycle between.
    load(8'hE9, 1'b0, 1'b0);
    run_frame("b2b_f1", ExpE9, 10, 1'b1, 1'b0);
    @(negedge clk);
    bus.DATA_VALID = 1'b0;
    check("b2b_f2_start", bus.TX_OUT, 1'b0);
    check("b2b_f2_busy", bus.BUSY, 1'b1);
    for (int j = 1; j < 10; j++) begin
      @(negedge clk);
      check($sformatf("b2b_f2_bit%0d", j), bus.TX_OUT, ExpE9[9-j]);
      check($sformatf("b2b_f2_busy%0d", j), bus.BUSY, 1'b1);
    end
    @(negedge clk);
    check_idle("b2b_end");
    @(negedge clk);
    check_idle("b2b_quiet");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_top.md
# uart_tx_top

Parallel-to-serial UART transmitter. Accepts an 8-bit word with a one-cycle valid qualifier and shifts out a standard asynchronous frame on a single line: start bit, 8 data bits LSB first, optional even/odd parity bit, and one stop bit. One bit is transmitted per clock cycle; any baud-rate enable is generated upstream. The block sits between the system-side data source and the serial pad.

## Interface

Parameters:
- DATA_WIDTH, 8, payload bits per frame. The only supported value is 8.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- P_DATA  in  8  parallel payload; captured on acceptance.
- DATA_VALID  in  1  request to send P_DATA; honoured only while idle.
- PAR_EN  in  1  1 = append parity bit (11-bit frame), 0 = no parity (10-bit frame); captured on acceptance.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity; captured on acceptance.
- TX_OUT  out  1  serial line, registered; idles high.
- BUSY  out  1  registered; high while a frame is in progress.

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0. If DATA_VALID=1 on a rising edge, latch P_DATA, PAR_EN and PAR_TYP, then go to START.
- START: TX_OUT=0, BUSY=1, then go to DATA with bit counter at 0.
- DATA: TX_OUT = latched data[counter], for counter 0..7 (LSB first).
  - After bit 7, go to PARITY if the latched PAR_EN is 1, otherwise go to STOP.
- PARITY: TX_OUT = XOR of the 8 latched data bits, XOR the latched PAR_TYP. Then go to STOP.
  - Even parity makes the total count of ones even; odd parity makes it odd.
- STOP: TX_OUT=1, BUSY=1, then go to IDLE.
- DATA_VALID, P_DATA, PAR_EN and PAR_TYP are ignored in every state other than IDLE. Changing these inputs mid-frame has no effect on the frame in progress.
- Parity is computed from the latched copy of the data, not from the live P_DATA input.

## Timing

- Reset: on a rising edge with RST=1, state=IDLE, TX_OUT=1, BUSY=0, bit counter=0, latches cleared. RST has priority over all other inputs.
- Reset asserted mid-frame aborts the frame. TX_OUT returns high at that same edge; no partial stop bit is sent.
- Acceptance at edge k: TX_OUT=0 and BUSY=1 are visible after edge k.
- Data bit i is driven after edge k+1+i.
- With parity: parity bit after edge k+9, stop bit after edge k+10, BUSY=0 and TX_OUT=1 after edge k+11. BUSY is high for 11 cycles.
- Without parity: stop bit after edge k+9, BUSY=0 after edge k+10. BUSY is high for 10 cycles.
- Back-to-back frames: after STOP there is always at least one IDLE cycle (TX_OUT=1, BUSY=0). DATA_VALID held high is accepted on the first IDLE edge.
- DATA_VALID is level-sensitive in IDLE. The source must deassert it, or present new data, once BUSY rises, or the same word is sent again.

## Configuration

- Macro UART_TX_PARITY_EN.
- Defined: parity logic and the PARITY state are compiled in, and PAR_EN/PAR_TYP behave as described above.
- Not defined:
  - Parity hardware and the PARITY state are removed.
  - PAR_EN and PAR_TYP are ignored.
  - Every frame is 10 bits (start, 8 data, stop) and BUSY is high for 10 cycles.

## Test plan

- Reset: hold RST=1 for 2 edges with DATA_VALID=1 -> TX_OUT=1 and BUSY=0 throughout; no frame starts until RST=0.
- Even parity: P_DATA=0xA9, PAR_EN=1, PAR_TYP=0, single-cycle DATA_VALID -> TX_OUT sequence 0,1,0,0,1,0,1,0,1,0,1; BUSY high for exactly 11 cycles.
- Odd parity: P_DATA=0xAB, PAR_EN=1, PAR_TYP=1 -> TX_OUT sequence 0,1,1,0,1,0,1,0,1,0,1 (parity 0, since 0xAB has five ones).
- No parity: P_DATA=0xE9, PAR_EN=0 -> TX_OUT sequence 0,1,0,0,1,0,1,1,1,1; BUSY high for exactly 10 cycles.
- Mid-frame input changes: after acceptance of 0x55, change P_DATA to 0xFF, toggle PAR_TYP and pulse DATA_VALID during the DATA state -> the frame still carries 0x55 with the original parity; a single frame only.
- Mid-frame reset, plus back-to-back: assert RST during data bit 3 -> TX_OUT=1 and BUSY=0 at the next edge. Separately, hold DATA_VALID high across two frames -> exactly one idle cycle (TX_OUT=1, BUSY=0) between them.
